ddr_byte_bridge: RTL



---
 rtl/ddr_byte_bridge_pkg.sv | 30 +++
 rtl/ddr_toggle_req.sv | 36 +++
 rtl/ddr_byte_bridge.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ddr_byte_bridge_pkg.sv
// Shared types and byte-lane helpers for the byte-wide DDR side-channel bridge.
package ddr_byte_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam int WORD_BYTES = 8;
  localparam int WADDR_W    = 25;

  function automatic logic [7:0] lane_sel(input logic [63:0] word, input logic [2:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] lane_be(input logic [2:0] lane);
    return 8'h01 << lane;
  endfunction

  function automatic logic [63:0] lane_merge(input logic [63:0] word, input logic [7:0] data,
                                             input logic [2:0] lane);
    logic [63:0] merged;
    merged = word;
    merged[{lane, 3'b000} +: 8] = data;
    return merged;
  endfunction

endpackage

// File: rtl/ddr_toggle_req.sv
// Toggle-handshake requester: N request toggles sharing one completion toggle.
// Request levels and the pending flag are kept outside reset.
module ddr_toggle_req #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] issue,
  input  logic             ack,
  output logic [N_REQ-1:0] req,
  output logic             ack_seen,
  output logic             pend
);

  logic [N_REQ-1:0] req_r = {N_REQ{1'b0}};
  logic             pend_r = 1'b0;
  logic             ack_prev_r;

  assign ack_seen = ack ^ ack_prev_r;
  assign req      = req_r;
  assign pend     = pend_r;

  // Toggle issue and outstanding tracking; ack_prev follows ack every cycle
  always_ff @(posedge clk) begin
    ack_prev_r <= ack;
    if (rst_n && (|issue)) begin
      req_r  <= req_r ^ issue;
      pend_r <= 1'b1;
    end else if (ack_seen) begin
      pend_r <= 1'b0;
    end else begin
      pend_r <= pend_r;
    end
  end

endmodule

// File: rtl/ddr_byte_bridge.sv
// Byte-wide CPU port onto the 64-bit toggle-handshake DDR side channel.
// Optional one-entry line cache: define DDR_BYTE_BRIDGE_LINE_CACHE_EN.
module ddr_byte_bridge
  import ddr_byte_bridge_pkg::*;
#(
  parameter int ADDR_W = 28
) (
  input  logic              CLK_VIDEO,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_busy,
  output logic [24:0]       s_addr,
  output logic              s_rd,
  output logic              s_wr,
  output logic [63:0]       s_din,
  output logic [7:0]        s_be,
  input  logic [63:0]       s_dout,
  input  logic              s_ack
);

  state_t       state_r, state_s;
  logic [7:0]   cpu_dout_r;
  logic         busy_r;
  logic [24:0]  s_addr_r;
  logic [63:0]  s_din_r;
  logic [7:0]   s_be_r;
  logic [2:0]   lane_r;

  logic [24:0]  word_addr_s;
  logic [2:0]   lane_s;
  logic         accept_s, wr_go_s, rd_req_s, rd_go_s, hit_s;
  logic [7:0]   hit_byte_s;
  logic [1:0]   req_s;
  logic         ack_seen_s, pend_s;

  assign word_addr_s = WADDR_W'(cpu_addr[ADDR_W-1:3]);
  assign lane_s      = cpu_addr[2:0];
  assign accept_s    = (state_r == IDLE) && !busy_r;
  // Write wins when both strobes arrive together
  assign wr_go_s     = accept_s && cpu_wr;
  assign rd_req_s    = accept_s && cpu_rd && !cpu_wr;
  assign rd_go_s     = rd_req_s && !hit_s;

  ddr_toggle_req #(.N_REQ(2)) u_req (
    .clk      (CLK_VIDEO),
    .rst_n    (RESET_N),
    .issue    ({wr_go_s, rd_go_s}),
    .ack      (s_ack),
    .req      (req_s),
    .ack_seen (ack_seen_s),
    .pend     (pend_s)
  );

`ifdef DDR_BYTE_BRIDGE_LINE_CACHE_EN
  logic [24:0] line_addr_r;
  logic [63:0] line_data_r;
  logic        line_vld_r;

  assign hit_s      = rd_req_s && line_vld_r && (line_addr_r == word_addr_s);
  assign hit_byte_s = lane_sel(line_data_r, lane_s);

  // Line fill on read completion, write-through merge at write issue
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      line_vld_r  <= 1'b0;
      line_addr_r <= 25'd0;
      line_data_r <= 64'd0;
    end else if ((state_r == RD_WAIT) && ack_seen_s) begin
      line_vld_r  <= 1'b1;
      line_addr_r <= s_addr_r;
      line_data_r <= s_dout;
    end else if (wr_go_s && line_vld_r && (line_addr_r == word_addr_s)) begin
      line_data_r <= lane_merge(line_data_r, cpu_din, lane_s);
    end else begin
      line_data_r <= line_data_r;
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_byte_s = 8'h00;
`endif

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (wr_go_s)      state_s = WR_WAIT;
        else if (rd_go_s) state_s = RD_WAIT;
        else              state_s = IDLE;
      end
      RD_WAIT, WR_WAIT, DRAIN: begin
        if (ack_seen_s) state_s = IDLE;
        else            state_s = state_r;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, request fields and CPU-side outputs
  always_ff @(posedge CLK_VIDEO) begin
    if (!RESET_N) begin
      // An ack landing on the last reset cycle retires the request already
      state_r    <= (pend_s && !ack_seen_s) ? DRAIN : IDLE;
      cpu_dout_r <= 8'h00;
      busy_r     <= 1'b0;
      s_addr_r   <= 25'd0;
      s_din_r    <= 64'd0;
      s_be_r     <= 8'h00;
      lane_r     <= 3'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (wr_go_s) begin
            s_addr_r <= word_addr_s;
            s_din_r  <= {WORD_BYTES{cpu_din}};
            s_be_r   <= lane_be(lane_s);
            busy_r   <= 1'b1;
          end else if (rd_go_s) begin
            s_addr_r <= word_addr_s;
            lane_r   <= lane_s;
            busy_r   <= 1'b1;
          end else if (hit_s) begin
            cpu_dout_r <= hit_byte_s;
            busy_r     <= 1'b0;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (ack_seen_s) begin
            cpu_dout_r <= lane_sel(s_dout, lane_r);
            busy_r     <= 1'b0;
          end else begin
            busy_r <= 1'b1;
          end
        end
        WR_WAIT, DRAIN: begin
          busy_r <= !ack_seen_s;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign cpu_dout = cpu_dout_r;
  assign cpu_busy = busy_r;
  assign s_addr   = s_addr_r;
  assign s_din    = s_din_r;
  assign s_be     = s_be_r;
  assign s_rd     = req_s[0];
  assign s_wr     = req_s[1];

endmodule
